// File: rtl/seed_collector.sv
// seed_collector: gathers eleven N-bit random words into a ChaCha20 key/nonce set.
// The collection cycle per request is: optional warm-up discard, then sampling, then hold until ack.
//
// Parameters:
//   N       width of rand_in (one word per cycle)
//   WARMUP  cycles discarded after a request before sampling (0..255)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   rand_in    N-bit random word from the upstream LFSR
//   req        level request for a new key/nonce set (honoured only in IDLE)
//   ack        consumer acknowledge (honoured only in PRESENT)
//   busy       high while warming up or collecting
//   valid      key_out/nonce_out hold a complete set
//   key_out    8*N-bit key; word 0 occupies bits [N-1:0]
//   nonce_out  3*N-bit nonce; word 8 occupies bits [N-1:0]
//   zero_rej   saturating count of rejected all-zero words
//
// Build option:
//   SEED_REJECT_ZERO_EN  when defined, all-zero words are dropped during collection
//                        and counted in zero_rej; otherwise zeros are stored and zero_rej is 0.

module seed_collector #(
   parameter int N      = 32,
   parameter int WARMUP = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   rand_in,
   input  logic           req,
   input  logic           ack,
   output logic           busy,
   output logic           valid,
   output logic [8*N-1:0] key_out,
   output logic [3*N-1:0] nonce_out,
   output logic [7:0]     zero_rej
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WARMUP  = 2'd1;
   localparam logic [1:0] S_COLLECT = 2'd2;
   localparam logic [1:0] S_PRESENT = 2'd3;

   localparam int         NWORDS    = 11;
   localparam logic [3:0] LAST_IDX  = 4'(NWORDS - 1);

   // Counter is loaded with WARMUP-1 on entry and WARMUP is left when it
   // reads zero, giving exactly WARMUP cycles in that state.
   localparam logic [7:0] WARM_LOAD = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;
   localparam bit         SKIP_WARM = (WARMUP == 0);

   logic [1:0]                state_q, state_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [3:0]                idx_q, idx_d;
   logic [NWORDS-1:0][N-1:0]  buf_q, buf_d;
   logic [8*N-1:0]            key_q, key_d;
   logic [3*N-1:0]            nonce_q, nonce_d;
   logic                      word_ok;

`ifdef SEED_REJECT_ZERO_EN
   logic [7:0]                rej_q, rej_d;

   assign word_ok  = (rand_in != '0);
   assign zero_rej = rej_q;
`else
   assign word_ok  = 1'b1;
   assign zero_rej = 8'd0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      key_d   = key_q;
      nonce_d = nonce_q;
`ifdef SEED_REJECT_ZERO_EN
      rej_d   = rej_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (req) begin
               idx_d = 4'd0;
               if (SKIP_WARM) begin
                  state_d = S_COLLECT;
               end else begin
                  state_d = S_WARMUP;
                  cnt_d   = WARM_LOAD;
               end
            end
         end

         S_WARMUP: begin
            if (cnt_q == 8'd0) begin
               state_d = S_COLLECT;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         S_COLLECT: begin
            if (word_ok) begin
               buf_d[idx_q] = rand_in;
               if (idx_q == LAST_IDX) begin
                  // Publish from buf_d so the 11th word lands on this edge.
                  key_d   = buf_d[7:0];
                  nonce_d = buf_d[10:8];
                  idx_d   = 4'd0;
                  state_d = S_PRESENT;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
`ifdef SEED_REJECT_ZERO_EN
            else if (rej_q != 8'hFF) begin
               rej_d = rej_q + 8'd1;
            end
`endif
         end

         S_PRESENT: begin
            // req is deliberately ignored here even if ack is high with it.
            if (ack) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= 4'd0;
         buf_q   <= '0;
         key_q   <= '0;
         nonce_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         key_q   <= key_d;
         nonce_q <= nonce_d;
      end
   end

`ifdef SEED_REJECT_ZERO_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rej_q <= 8'd0;
      end else begin
         rej_q <= rej_d;
      end
   end
`endif

   assign busy      = (state_q == S_WARMUP) || (state_q == S_COLLECT);
   assign valid     = (state_q == S_PRESENT);
   assign key_out   = key_q;
   assign nonce_out = nonce_q;

endmodule

// File: tb/tb_seed_collector.sv
// tb_seed_collector: directed bench for seed_collector (WARMUP=16 and WARMUP=0 instances).
// Edges are numbered with the edge that samples req in IDLE as edge 1.

module tb_seed_collector;

   localparam int N = 32;

`ifdef SEED_REJECT_ZERO_EN
   localparam bit REJ_EN = 1'b1;
`else
   localparam bit REJ_EN = 1'b0;
`endif

   typedef logic [N-1:0] seq_t [16];

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   rin_a, rin_b;
   logic           req_a, ack_a, req_b, ack_b;
   logic           busy_a, valid_a, busy_b, valid_b;
   logic [8*N-1:0] key_a, key_b;
   logic [3*N-1:0] non_a, non_b;
   logic [7:0]     zr_a, zr_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seed_collector #(.N(N), .WARMUP(16)) dut_a (
      .clk(clk), .rst(rst), .rand_in(rin_a), .req(req_a), .ack(ack_a),
      .busy(busy_a), .valid(valid_a), .key_out(key_a),
      .nonce_out(non_a), .zero_rej(zr_a)
   );

   seed_collector #(.N(N), .WARMUP(0)) dut_b (
      .clk(clk), .rst(rst), .rand_in(rin_b), .req(req_b), .ack(ack_b),
      .busy(busy_b), .valid(valid_b), .key_out(key_b),
      .nonce_out(non_b), .zero_rej(zr_b)
   );

   // Issues one req pulse to dut_a (called at a negedge, dut_a idle) and
   // feeds seq[k] so that it is sampled on edge 18+k. Returns the edge on
   // which valid first appears (-1 if it never does within 60 edges).
   task automatic drive_a(input seq_t seq, output int vedge, output int bcyc);
      req_a = 1'b1;
      rin_a = 32'hDEAD_0000;
      vedge = -1;
      bcyc  = 0;
      for (int e = 1; e <= 60 && vedge < 0; e++) begin
         @(posedge clk);
         @(negedge clk);
         req_a = 1'b0;
         if (busy_a) bcyc++;
         if (valid_a) vedge = e;
         if (e >= 17 && e - 17 < 16) rin_a = seq[e-17];
         else if (e >= 17) rin_a = 32'hFFFF_0000;
         else rin_a = 32'hDEAD_0000 + N'(e);
      end
   endtask

   task automatic ack_dut_a;
      ack_a = 1'b1;
      @(negedge clk);
      ack_a = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_a = 0; ack_a = 0; req_b = 0; ack_b = 0;
      rin_a = '0; rin_b = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy_a, valid_a, busy_b, valid_b} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000", {busy_a, valid_a, busy_b, valid_b});
      end
      checks++;
      if (key_a !== '0 || non_a !== '0 || zr_a !== 8'd0) begin
         errors++;
         $display("FAIL reset_data got key %h nonce %h zr %0d want zeros", key_a, non_a, zr_a);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_warmup16;
      seq_t seq;
      int vedge, bcyc;
      logic [8*N-1:0] ek;
      logic [3*N-1:0] en;
      for (int k = 0; k < 16; k++) seq[k] = N'(k + 1);
      for (int k = 0; k < 8; k++) ek[k*N +: N] = N'(k + 1);
      for (int k = 0; k < 3; k++) en[k*N +: N] = N'(k + 9);
      drive_a(seq, vedge, bcyc);
      checks++;
      if (vedge !== 28) begin
         errors++;
         $display("FAIL w16_valid_edge got %0d want 28", vedge);
      end
      checks++;
      if (bcyc !== 27) begin
         errors++;
         $display("FAIL w16_busy_cycles got %0d want 27", bcyc);
      end
      checks++;
      if (key_a !== ek) begin
         errors++;
         $display("FAIL w16_key got %h want %h", key_a, ek);
      end
      checks++;
      if (non_a !== en) begin
         errors++;
         $display("FAIL w16_nonce got %h want %h", non_a, en);
      end
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL w16_busy_present got %b want 0", busy_a);
      end
   endtask

   task automatic test_hold;
      logic [8*N-1:0] pk;
      logic [3*N-1:0] pn;
      int vedge;
      pk = key_a;
      pn = non_a;
      for (int i = 0; i < 50; i++) begin
         rin_a = $urandom;
         req_a = i[0];
         @(negedge clk);
         checks++;
         if (valid_a !== 1'b1 || key_a !== pk || non_a !== pn) begin
            errors++;
            $display("FAIL hold_%0d got v %b key %h nonce %h want v 1 key %h nonce %h",
                     i, valid_a, key_a, non_a, pk, pn);
         end
      end
      req_a = 1'b1;
      ack_a = 1'b1;
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL ack_to_idle got v %b busy %b want 0 0", valid_a, busy_a);
      end
      ack_a = 1'b0;
      rin_a = 32'hC0DE_0000;
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b1) begin
         errors++;
         $display("FAIL held_req_restart got busy %b want 1", busy_a);
      end
      req_a = 1'b0;
      vedge = -1;
      for (int e = 0; e < 40 && vedge < 0; e++) begin
         rin_a = 32'hC0DE_0000 + N'(e);
         @(negedge clk);
         if (valid_a) vedge = e;
      end
      checks++;
      if (vedge < 0) begin
         errors++;
         $display("FAIL restart_complete got no valid want valid within 40");
      end
      ack_dut_a();
   endtask

   task automatic test_reset_mid;
      seq_t seq;
      int vedge, bcyc;
      logic [8*N-1:0] pk, ek;
      logic [3*N-1:0] en;
      pk = key_a;
      req_a = 1'b1;
      rin_a = 32'hDEAD_0000;
      for (int e = 1; e <= 22; e++) begin
         @(posedge clk);
         @(negedge clk);
         req_a = 1'b0;
         rin_a = (e >= 17) ? N'(50 + e - 17) : 32'hDEAD_0000;
      end
      checks++;
      if (busy_a !== 1'b1 || key_a !== pk) begin
         errors++;
         $display("FAIL mid_collect got busy %b key %h want 1 key %h", busy_a, key_a, pk);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy_a, valid_a} !== 2'b00 || key_a !== '0 || non_a !== '0 || zr_a !== 8'd0) begin
         errors++;
         $display("FAIL async_reset got busy %b v %b key %h nonce %h zr %0d want zeros",
                  busy_a, valid_a, key_a, non_a, zr_a);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 16; k++) seq[k] = N'(100 + k);
      for (int k = 0; k < 8; k++) ek[k*N +: N] = N'(100 + k);
      for (int k = 0; k < 3; k++) en[k*N +: N] = N'(108 + k);
      drive_a(seq, vedge, bcyc);
      checks++;
      if (vedge !== 28 || key_a !== ek || non_a !== en) begin
         errors++;
         $display("FAIL fresh_set got edge %0d key %h nonce %h want 28 key %h nonce %h",
                  vedge, key_a, non_a, ek, en);
      end
      ack_dut_a();
   endtask

   task automatic test_warmup0;
      int vedge, bcyc;
      logic [8*N-1:0] ek;
      logic [3*N-1:0] en;
      for (int k = 0; k < 8; k++) ek[k*N +: N] = 32'hA5A5_0000 + N'(k + 2);
      for (int k = 0; k < 3; k++) en[k*N +: N] = 32'hA5A5_0000 + N'(k + 10);
      req_b = 1'b1;
      rin_b = 32'hA5A5_0001;
      vedge = -1;
      bcyc = 0;
      for (int e = 1; e <= 30 && vedge < 0; e++) begin
         @(posedge clk);
         @(negedge clk);
         req_b = 1'b0;
         if (busy_b) bcyc++;
         if (valid_b) vedge = e;
         rin_b = 32'hA5A5_0000 + N'(e + 1);
      end
      checks++;
      if (vedge !== 12) begin
         errors++;
         $display("FAIL w0_valid_edge got %0d want 12", vedge);
      end
      checks++;
      if (bcyc !== 11) begin
         errors++;
         $display("FAIL w0_busy_cycles got %0d want 11", bcyc);
      end
      checks++;
      if (key_b !== ek || non_b !== en) begin
         errors++;
         $display("FAIL w0_set got key %h nonce %h want key %h nonce %h", key_b, non_b, ek, en);
      end
      ack_b = 1'b1;
      @(negedge clk);
      ack_b = 1'b0;
      checks++;
      if (valid_b !== 1'b0) begin
         errors++;
         $display("FAIL w0_ack got v %b want 0", valid_b);
      end
   endtask

   task automatic test_zero_words;
      seq_t seq;
      int vedge, bcyc, acc, used, rej;
      logic [N-1:0] w [11];
      logic [8*N-1:0] ek;
      logic [3*N-1:0] en;
      int raw [14] = '{1, 2, 0, 3, 0, 0, 4, 5, 6, 7, 8, 9, 10, 11};
      for (int k = 0; k < 16; k++) seq[k] = (k < 14) ? N'(raw[k]) : N'(k);
      acc = 0;
      used = 0;
      rej = 0;
      while (acc < 11) begin
         if (REJ_EN && seq[used] == '0) begin
            rej++;
         end else begin
            w[acc] = seq[used];
            acc++;
         end
         used++;
      end
      for (int k = 0; k < 8; k++) ek[k*N +: N] = w[k];
      for (int k = 0; k < 3; k++) en[k*N +: N] = w[k+8];
      drive_a(seq, vedge, bcyc);
      checks++;
      if (vedge !== 17 + used) begin
         errors++;
         $display("FAIL zero_valid_edge got %0d want %0d", vedge, 17 + used);
      end
      checks++;
      if (zr_a !== 8'(rej)) begin
         errors++;
         $display("FAIL zero_rej got %0d want %0d", zr_a, rej);
      end
      checks++;
      if (key_a !== ek || non_a !== en) begin
         errors++;
         $display("FAIL zero_set got key %h nonce %h want key %h nonce %h", key_a, non_a, ek, en);
      end
      ack_dut_a();
   endtask

   initial begin
      test_reset();
      test_warmup16();
      test_hold();
      test_reset_mid();
      test_warmup0();
      test_zero_words();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seed_collector.md
SEED_COLLECTOR -- requirements
Module: seed_collector

Interface
REQ-001 SHALL have parameter N, default 32, the width of the random word consumed per cycle.
REQ-002 SHALL have parameter WARMUP, default 16, the number of cycles discarded after each request before sampling starts (range 0..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rand_in, input, N bits: random word from the upstream LFSR seed generator, sampled every cycle in COLLECT.
REQ-006 SHALL have port req, input, 1 bit: level request for a new key/nonce set.
REQ-007 SHALL have port ack, input, 1 bit: consumer acknowledge of the presented set.
REQ-008 SHALL have port busy, output, 1 bit: high in WARMUP and COLLECT.
REQ-009 SHALL have port valid, output, 1 bit: key_out and nonce_out hold a complete set.
REQ-010 SHALL have port key_out, output, 8*N bits: ChaCha20 key.
REQ-011 SHALL have port nonce_out, output, 3*N bits: ChaCha20 nonce.
REQ-012 SHALL have port zero_rej, output, 8 bits: count of rejected zero words (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, WARMUP, COLLECT, PRESENT.
REQ-014 SHALL move IDLE->WARMUP on req=1, or IDLE->COLLECT when WARMUP=0.
REQ-015 SHALL stay in WARMUP exactly WARMUP cycles via an 8-bit down-counter, then enter COLLECT.
REQ-016 SHALL sample rand_in on each COLLECT cycle into an 11-word internal buffer; word 0 -> key bits [N-1:0], words 0..7 -> key ascending, words 8..10 -> nonce bits ascending.
REQ-017 SHALL leave COLLECT after the 11th accepted word, copy the buffer to key_out/nonce_out on that same edge, and enter PRESENT.
REQ-018 SHALL assert valid only in PRESENT; with WARMUP=W, valid rises W+12 edges after the edge sampling req in IDLE.
REQ-019 SHALL hold key_out/nonce_out stable from PRESENT until the next COLLECT completion; they SHALL NOT change during WARMUP/COLLECT.
REQ-020 SHALL return PRESENT->IDLE on ack=1; valid deasserts on that edge.
REQ-021 SHALL ignore req outside IDLE, including req and ack high together in PRESENT; a held req restarts from IDLE on the following cycle.
REQ-022 SHALL ignore ack outside PRESENT.

Reset
REQ-023 SHALL on rst=1 immediately force state IDLE, busy=0, valid=0, key_out=0, nonce_out=0, zero_rej=0, and clear buffer and counters.
REQ-024 SHALL abort any WARMUP/COLLECT in progress on reset; no partial set SHALL ever appear at the outputs.

Configuration
REQ-025 SHALL, when macro SEED_REJECT_ZERO_EN is defined, reject any all-zero rand_in in COLLECT: not stored, word index not advanced, zero_rej incremented and saturating at 255, cleared only by reset.
REQ-026 SHALL, without SEED_REJECT_ZERO_EN, store zero words like any other, and tie zero_rej to 0.

Verification
REQ-027 SHALL cover: reset, WARMUP=16, req pulse, rand_in = 1,2,3... from the first COLLECT cycle -> valid at edge 28, key_out word0=1..word7=8, nonce words 9,10,11.
REQ-028 SHALL cover: WARMUP=0, req, rand_in=32'hA5A5_0000+cycle -> valid at edge 12, busy high for 11 cycles.
REQ-029 SHALL cover: valid held with ack=0 for 50 cycles while rand_in toggles -> key_out/nonce_out unchanged; ack=1 -> valid=0 next cycle, state IDLE.
REQ-030 SHALL cover: rst asserted mid-COLLECT after 5 words -> outputs all zero at once; new req yields a full fresh 11-word set.
REQ-031 SHALL cover: with SEED_REJECT_ZERO_EN, 3 zero words inserted in COLLECT -> valid delayed 3 cycles, zero_rej=3, no zero word in key/nonce; without macro -> zeros stored, zero_rej=0.
